caravel_clock_ctrl: RTL
=======================

# caravel_clock_ctrl

Sequencer that owns the configuration inputs of the clock-generation block (`ext_clk_sel`, `sel`, `sel2`) and changes them only in a safe order. It accepts a request from housekeeping over a valid/ready handshake. It parks the core on the external clock, reprograms both PLL dividers, waits for settling, then returns to the PLL clock if requested. It runs on `core_clk`, the output of the clock-generation block.

## Interface
- `SWITCH_CYCLES`, 4: cycles held after any `ext_clk_sel` change; legal range 2..255.
- `SETTLE_CYCLES`, 16: cycles held after a divider change; legal range 1..255.
- `PLL_STARTUP_CYCLES`, 64: minimum settle when the PLL is re-enabled (see Configuration); legal range 1..255.
- `core_clk` input 1: sole clock; all logic on its rising edge.
- `resetb` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller idle, will accept.
- `req_ext` input 1: target source; 1 = external clock, 0 = PLL.
- `req_sel` input 3: target core divider.
- `req_sel2` input 3: target user divider.
- `ext_clk_sel` output 1: to clock block; 1 = external clock.
- `sel` output 3: to clock block, core divider.
- `sel2` output 3: to clock block, user divider.
- `pll_ena` output 1: PLL enable (see Configuration).
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle pulse at sequence completion.

## Operation
- Reset values:
  - `ext_clk_sel`=1.
  - `sel`=0, `sel2`=0.
  - `req_ready`=1, `busy`=0, `done`=0.
  - `pll_ena`=0 with the macro defined, 1 without it.
- `busy` = ~`req_ready`, always.
- Accept: `req_valid`&&`req_ready` sampled high at an edge. `req_ext`, `req_sel` and `req_sel2` are latched internally at that edge. Later changes on the request inputs have no effect.
- While busy, `req_ready`=0 and `req_valid` is ignored. No queueing.
- States:
  - IDLE → PARK on accept.
  - PARK: drive `ext_clk_sel`=1, then go to WAIT_PARK.
  - WAIT_PARK: hold `SWITCH_CYCLES` cycles, then go to CFG.
  - CFG: load `sel`/`sel2` from the latched values, then go to SETTLE.
  - SETTLE: hold the settle count, then go to RETURN if the latched `req_ext`=0, else to FIN.
  - RETURN: drive `ext_clk_sel`=0, then go to WAIT_RET.
  - WAIT_RET: hold `SWITCH_CYCLES` cycles, then go to FIN.
  - FIN: pulse `done`, set `req_ready`=1, go to IDLE.
- Timing is uniform: PARK and its wait always execute, even when `ext_clk_sel` is already 1. Divider values are always rewritten, even when unchanged.
- `sel`/`sel2` change only while `ext_clk_sel`=1 and at least `SWITCH_CYCLES` after it rose.
- Wait counter is 8-bit, loaded with N−1 and counts down to 0. No wrap is possible within the legal ranges.
- Reset mid-sequence: at the next edge with `resetb`=0, all outputs take their reset values and the state returns to IDLE. No `done` pulse is produced.

## Timing
- E0 = accept edge. S = `SWITCH_CYCLES`, T = settle count (`SETTLE_CYCLES`, or per Configuration).
- `req_ready` falls at E0+1.
- `ext_clk_sel`=1 from E0+1.
- `sel`/`sel2` update at E0+1+S.
- PLL target:
  - `ext_clk_sel` falls at E0+1+S+T.
  - `done`=1 and `req_ready`=1 at E0+1+2S+T, for exactly one cycle of `done`.
- External target: `done` and `req_ready` at E0+1+S+T; `ext_clk_sel` stays 1.
- Back-to-back: a new request may be accepted at the first edge where `req_ready`=1 (the `done` cycle's edge+1 sample).

## Configuration
- Macro `CLOCK_CTRL_PLL_GATE_EN`.
- Defined:
  - `pll_ena` is registered.
  - External-target sequence: `pll_ena` falls at the FIN edge.
  - PLL-target sequence with `pll_ena`=0: `pll_ena` rises at the CFG edge, and T = max(`SETTLE_CYCLES`, `PLL_STARTUP_CYCLES`).
  - Otherwise T = `SETTLE_CYCLES`.
- Not defined:
  - `pll_ena` is constant 1.
  - T is always `SETTLE_CYCLES`.
  - `PLL_STARTUP_CYCLES` is unused.

## Test plan
- Reset with `resetb`=0 for 2 edges → `ext_clk_sel`=1, `sel`=`sel2`=0, `req_ready`=1, `done`=0; `pll_ena`=0 with macro, 1 without.
- Defaults, macro off, request `req_ext`=0, `req_sel`=3, `req_sel2`=5 at E0:
  - `ext_clk_sel`=1 at E1.
  - `sel`=3 and `sel2`=5 at E5.
  - `ext_clk_sel`=0 at E21.
  - `done` high one cycle at E25; `req_ready`=1 at E25.
- Request `req_ext`=1, `req_sel`=2 at E0 → `sel`=2 at E5; `done` at E21; `ext_clk_sel` stays 1.
- Toggle `req_valid` and the request fields during the busy window → outputs unchanged from the latched request; exactly one `done`.
- Drive `resetb`=0 at E10 of a PLL sequence → all outputs at reset values from E11; no `done`; a new request is accepted normally afterwards.
- Macro on, from reset, request `req_ext`=0 →
  - `pll_ena` rises at E5.
  - `ext_clk_sel` falls at E69.
  - `done` at E73.
  - A following `req_ext`=1 request drops `pll_ena` on its `done` edge.

Source files
------------

// File: rtl/caravel_clock_ctrl.sv
// caravel_clock_ctrl: sequences the clock-generation block configuration so
// that the core is parked on the external clock before any divider change.
//
// Ports:
//   core_clk, resetb             clock, synchronous active-low reset
//   req_valid/req_ready          request handshake from housekeeping
//   req_ext, req_sel, req_sel2   requested source and dividers
//   ext_clk_sel, sel, sel2       registered drives to the clock block
//   pll_ena                      PLL enable
//   busy, done                   sequence in progress, completion pulse
//
// Build option: define CLOCK_CTRL_PLL_GATE_EN to make pll_ena a register
// that gates the PLL off while parked on the external clock, with a longer
// settle when the PLL is restarted. Without it pll_ena is tied high.

module caravel_clock_ctrl #(
    parameter int unsigned SWITCH_CYCLES      = 4,
    parameter int unsigned SETTLE_CYCLES      = 16,
    parameter int unsigned PLL_STARTUP_CYCLES = 64
) (
    input  logic       core_clk,
    input  logic       resetb,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_ext,
    input  logic [2:0] req_sel,
    input  logic [2:0] req_sel2,
    output logic       ext_clk_sel,
    output logic [2:0] sel,
    output logic [2:0] sel2,
    output logic       pll_ena,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] SW_LD  = 8'(SWITCH_CYCLES - 1);
    localparam logic [7:0] SET_LD = 8'(SETTLE_CYCLES - 1);
    localparam int unsigned LONG_T =
        (PLL_STARTUP_CYCLES > SETTLE_CYCLES) ?
        PLL_STARTUP_CYCLES : SETTLE_CYCLES;
    localparam logic [7:0] LONG_LD = 8'(LONG_T - 1);

    // Each state is entered on the edge that performs the action named
    // before it (park, divider load, return), so registered outputs
    // change exactly at the transition edge.
    typedef enum logic [1:0] {
        IDLE,
        WAIT_PARK,
        SETTLE,
        WAIT_RET
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       cnt_zero;
    logic       ext_tgt_q;
    logic [2:0] sel_tgt_q;
    logic [2:0] sel2_tgt_q;
    logic       ext_q;
    logic [2:0] sel_q;
    logic [2:0] sel2_q;
    logic       ready_q;
    logic       done_q;
    logic       need_long;

    assign cnt_d    = cnt_q - 8'd1;
    assign cnt_zero = (cnt_q == 8'd0);

`ifdef CLOCK_CTRL_PLL_GATE_EN
    logic pll_ena_q;
    // Restarting a stopped PLL needs the longer startup settle.
    assign need_long = ~ext_tgt_q & ~pll_ena_q;
    assign pll_ena   = pll_ena_q;
`else
    assign need_long = 1'b0;
    assign pll_ena   = 1'b1;
`endif

    always_ff @(posedge core_clk) begin
        if (!resetb) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ext_tgt_q  <= 1'b1;
            sel_tgt_q  <= 3'd0;
            sel2_tgt_q <= 3'd0;
            ext_q      <= 1'b1;
            sel_q      <= 3'd0;
            sel2_q     <= 3'd0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef CLOCK_CTRL_PLL_GATE_EN
            pll_ena_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        ext_tgt_q  <= req_ext;
                        sel_tgt_q  <= req_sel;
                        sel2_tgt_q <= req_sel2;
                        ready_q    <= 1'b0;
                        ext_q      <= 1'b1;
                        cnt_q      <= SW_LD;
                        state_q    <= WAIT_PARK;
                    end
                end
                WAIT_PARK: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_d;
                    end else begin
                        sel_q   <= sel_tgt_q;
                        sel2_q  <= sel2_tgt_q;
                        cnt_q   <= need_long ? LONG_LD : SET_LD;
                        state_q <= SETTLE;
`ifdef CLOCK_CTRL_PLL_GATE_EN
                        if (!ext_tgt_q) pll_ena_q <= 1'b1;
`endif
                    end
                end
                SETTLE: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_d;
                    end else if (!ext_tgt_q) begin
                        ext_q   <= 1'b0;
                        cnt_q   <= SW_LD;
                        state_q <= WAIT_RET;
                    end else begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
`ifdef CLOCK_CTRL_PLL_GATE_EN
                        pll_ena_q <= 1'b0;
`endif
                    end
                end
                WAIT_RET: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_d;
                    end else begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign busy        = ~ready_q;
    assign done        = done_q;
    assign ext_clk_sel = ext_q;
    assign sel         = sel_q;
    assign sel2        = sel2_q;

endmodule
